systolic_array: RTL and testbench

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

---
 rtl/systolic_array_pkg.sv | 17 +
 rtl/systolic_array_tpumac.sv | 81 ++++++++
 rtl/systolic_array.sv | 97 +++++++++
 tb/tb_systolic_array.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// Shared defaults and derived timing constants for the systolic matrix multiplier.
// Latency: none (constants only).
// Backpressure: not applicable.
package systolic_array_pkg;

  localparam int BITS_AB_DEF = 8;
  localparam int BITS_C_DEF  = 16;
  localparam int DIM_DEF     = 8;

  // Enabled cycles for a full skewed DIM x DIM product to drain through the array.
  function automatic int done_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

  localparam int LATENCY_DEF = 3 * DIM_DEF - 2;

endpackage

// File: rtl/systolic_array_tpumac.sv
// tpumac: one processing element; forwards A right, B down, accumulates A*B.
// Latency: 1 cycle operand forwarding; accumulator visible the cycle after the edge.
// Backpressure: none; en stalls the element, clr > WrEn > en. Option: SYSTOLIC_SATURATE_EN.
module tpumac
  import systolic_array_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int BITS_C  = BITS_C_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);

  logic signed [BITS_AB-1:0]   a_q;
  logic signed [BITS_AB-1:0]   b_q;
  logic signed [BITS_C-1:0]    acc;
  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]    acc_nxt;

  assign prod = Ain * Bin;

`ifdef SYSTOLIC_SATURATE_EN
  // One guard bit beyond the wider of accumulator and product, so the sum never wraps.
  localparam int SW = ((BITS_C > 2 * BITS_AB) ? BITS_C : 2 * BITS_AB) + 1;
  logic signed [SW-1:0] sum;
  logic                 in_range;

  assign sum      = SW'(acc) + SW'(prod);
  assign in_range = (&sum[SW-1:BITS_C-1]) | ~(|sum[SW-1:BITS_C-1]);

  // Clamp to the accumulator range when the guard bits disagree with the sign bit.
  always_comb begin
    acc_nxt = sum[BITS_C-1:0];
    if (!in_range) begin
      acc_nxt = sum[SW-1] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    end
  end
`else
  // Plain two's-complement wrap; the product is sign-extended or truncated to BITS_C.
  always_comb begin
    acc_nxt = acc + BITS_C'(prod);
  end
`endif

  // Operand forwarding and accumulate/load; accumulation uses pre-update operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else if (clr) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else begin
      if (en) begin
        a_q <= Ain;
        b_q <= Bin;
      end
      if (WrEn) begin
        acc <= Cin;
      end else if (en) begin
        acc <= acc_nxt;
      end
    end
  end

  assign Aout = a_q;
  assign Bout = b_q;
  assign Cout = acc;

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic multiplier with row-addressed accumulator access.
// Latency: done after 3*DIM-2 enabled cycles; Cout is a combinational read of row Crow.
// Backpressure: none; en=0 stalls everything. Option: SYSTOLIC_SATURATE_EN (clamped sums).
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int BITS_C  = BITS_C_DEF,
  parameter int DIM     = DIM_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] A    [DIM],
  input  logic signed [BITS_AB-1:0] B    [DIM],
  input  logic [$clog2(DIM)-1:0]    Crow,
  input  logic signed [BITS_C-1:0]  Cin  [DIM],
  output logic signed [BITS_C-1:0]  Cout [DIM],
  output logic                      done
);

  localparam int ROW_W = $clog2(DIM);
  localparam int LAT   = done_cycles(DIM);
  localparam int CNT_W = $clog2(LAT + 1);

  logic signed [BITS_AB-1:0] a_out [DIM][DIM];
  logic signed [BITS_AB-1:0] b_out [DIM][DIM];
  logic signed [BITS_C-1:0]  acc   [DIM][DIM];
  logic [DIM-1:0]            row_wr;
  logic signed [BITS_AB-1:0] a_unused [DIM];
  logic signed [BITS_AB-1:0] b_unused [DIM];
  logic [CNT_W-1:0]          cnt;

  for (genvar r = 0; r < DIM; r++) begin : g_row
    assign row_wr[r]   = WrEn && (Crow == ROW_W'(r));
    // Operands leaving the last column / last row fall off the array.
    assign a_unused[r] = a_out[r][DIM-1];
    assign b_unused[r] = b_out[DIM-1][r];

    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic signed [BITS_AB-1:0] a_in;
      logic signed [BITS_AB-1:0] b_in;

      if (c == 0) begin : g_a_edge
        assign a_in = A[r];
      end else begin : g_a_int
        assign a_in = a_out[r][c-1];
      end

      if (r == 0) begin : g_b_edge
        assign b_in = B[c];
      end else begin : g_b_int
        assign b_in = b_out[r-1][c];
      end

      tpumac #(
        .BITS_AB(BITS_AB),
        .BITS_C (BITS_C)
      ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (clr),
        .WrEn (row_wr[r]),
        .Ain  (a_in),
        .Bin  (b_in),
        .Cin  (Cin[c]),
        .Aout (a_out[r][c]),
        .Bout (b_out[r][c]),
        .Cout (acc[r][c])
      );
    end
  end

  // Row read mux: present the accumulators of row Crow.
  always_comb begin
    for (int c = 0; c < DIM; c++) begin
      Cout[c] = acc[Crow][c];
    end
  end

  // Enabled-cycle counter; saturates at the drain latency, which raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(LAT));

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array at default parameters (8x8, 8-bit operands, 16-bit sums).
// Skewed matrix feeds, write/readback, clr and async reset; optional SYSTOLIC_SATURATE_EN.
// No backpressure; expected values are hand-derived constants or input matrices.
module tb_systolic_array;

  localparam int D = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                en;
  logic                clr;
  logic                WrEn;
  logic signed [7:0]   A    [D];
  logic signed [7:0]   B    [D];
  logic [2:0]          Crow;
  logic signed [15:0]  Cin  [D];
  logic signed [15:0]  Cout [D];
  logic                done;

  int total = 0;
  int bad   = 0;

  logic signed [7:0]  mm   [D][D];
  logic signed [7:0]  ma   [D][D];
  logic signed [7:0]  mb   [D][D];
  logic signed [15:0] mexp [D][D];
  logic signed [15:0] ovf_exp;

  always #5 clk = ~clk;

  systolic_array dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (clr),
    .WrEn (WrEn),
    .A    (A),
    .B    (B),
    .Crow (Crow),
    .Cin  (Cin),
    .Cout (Cout),
    .done (done)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < D; r++) begin
      @(negedge clk);
      Crow = 3'(r);
      #1;
      for (int c = 0; c < D; c++) chk($sformatf("%s[%0d][%0d]", tag, r, c), Cout[c], mexp[r][c]);
    end
  endtask

  // Feed skewed operands for global cycles t0 .. t0+n-1: row r delayed by r, column c by c.
  task automatic run(input int t0, input int n);
    for (int t = t0; t < t0 + n; t++) begin
      @(negedge clk);
      en = 1'b1;
      for (int r = 0; r < D; r++) A[r] = ((t - r) >= 0 && (t - r) < D) ? ma[r][t-r] : 8'sd0;
      for (int c = 0; c < D; c++) B[c] = ((t - c) >= 0 && (t - c) < D) ? mb[t-c][c] : 8'sd0;
    end
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < D; i++) begin
      A[i] = '0;
      B[i] = '0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // sel 0: A=I,B=M   sel 1: A=B=-128   sel 2: A=M,B=I
  task automatic load(input int sel);
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        case (sel)
          0:       begin ma[i][j] = (i == j) ? 8'sd1 : 8'sd0; mb[i][j] = mm[i][j]; end
          1:       begin ma[i][j] = -8'sd128;                 mb[i][j] = -8'sd128; end
          default: begin ma[i][j] = mm[i][j]; mb[i][j] = (i == j) ? 8'sd1 : 8'sd0; end
        endcase
      end
    end
  endtask

  task automatic exp_m();
    for (int i = 0; i < D; i++) for (int j = 0; j < D; j++) mexp[i][j] = mm[i][j];
  endtask

  task automatic exp_const(input logic signed [15:0] v);
    for (int i = 0; i < D; i++) for (int j = 0; j < D; j++) mexp[i][j] = v;
  endtask

  initial begin
`ifdef SYSTOLIC_SATURATE_EN
    ovf_exp = 16'sd32767;
`else
    ovf_exp = 16'sd0;
`endif
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) mm[i][j] = 8'((i * 29 + j * 13) % 256 - 128);
    end
    mm[7][7] = 8'sd127;

    en = 1'b0; clr = 1'b0; WrEn = 1'b0; Crow = '0;
    for (int i = 0; i < D; i++) begin
      A[i] = '0; B[i] = '0; Cin[i] = '0;
    end

    // Power-up reset
    #1 rst_n = 1'b0;
    #2;
    chk("reset_done", done, 0);
    exp_const(16'sd0);
    check_rows("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Identity x M: done must not rise after 21 cycles, only after 22
    load(0);
    run(0, 21);
    chk("done_at_21", done, 0);
    run(21, 1);
    chk("done_at_22", done, 1);
    run(22, 2);
    chk("done_holds", done, 1);
    exp_m();
    check_rows("ident");

    // All -128: eight products of 16384 per element
    do_clr();
    chk("clr_done", done, 0);
    load(1);
    run(0, 22);
    chk("ovf_done", done, 1);
    exp_const(ovf_exp);
    check_rows("ovf");

    // Row write with en low
    do_clr();
    @(negedge clk);
    WrEn = 1'b1; Crow = 3'd3;
    for (int c = 0; c < D; c++) Cin[c] = 16'(c * 100);
    @(negedge clk);
    WrEn = 1'b0;
    exp_const(16'sd0);
    for (int c = 0; c < D; c++) mexp[3][c] = 16'(c * 100);
    check_rows("wr");
    chk("wr_no_count", done, 0);

    // Write row 2 while the array accumulates A=1, B=2
    do_clr();
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < D; i++) begin
      A[i] = 8'sd1; B[i] = 8'sd2;
    end
    @(negedge clk);
    WrEn = 1'b1; Crow = 3'd2;
    for (int c = 0; c < D; c++) Cin[c] = 16'(1000 + c);
    @(negedge clk);
    en = 1'b0; WrEn = 1'b0;
    for (int i = 0; i < D; i++) begin
      A[i] = '0; B[i] = '0;
    end
    exp_const(16'sd0);
    mexp[0][0] = 16'sd4; mexp[0][1] = 16'sd2; mexp[1][0] = 16'sd2; mexp[1][1] = 16'sd2;
    for (int c = 0; c < D; c++) mexp[2][c] = 16'(1000 + c);
    check_rows("simul");

    // clr at cycle 10 of a run, then a complete M x I rerun
    do_clr();
    load(0);
    run(0, 10);
    @(negedge clk);
    clr = 1'b1; en = 1'b1;
    @(negedge clk);
    clr = 1'b0; en = 1'b0;
    chk("clr_mid_done", done, 0);
    exp_const(16'sd0);
    check_rows("clr_mid");
    load(2);
    run(0, 22);
    chk("rerun_done", done, 1);
    exp_m();
    check_rows("rerun");

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", done, 0);
    for (int c = 0; c < D; c++) chk($sformatf("arst_row7[%0d]", c), Cout[c], 0);
    exp_const(16'sd0);
    check_rows("arst");
    @(negedge clk);
    rst_n = 1'b1;
    load(0);
    run(0, 21);
    chk("post_rst_done21", done, 0);
    run(21, 1);
    chk("post_rst_done22", done, 1);
    exp_m();
    check_rows("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
